inst_fetch_aligner: RTL and testbench

Front-end block between the instruction memory port and `inst_decoder`. Fetches 4-byte-aligned 32-bit words, buffers them as halfwords, and presents one instruction per handshake: a full 32-bit instruction, or a 16-bit compressed instruction zero-extended with `is_rvc` set. Handles 32-bit instructions straddling a word boundary, pipeline redirects to any 2-byte-aligned PC, and discarding of stale memory responses. RVC expansion is done by a separate combinational stage between this block's output and `inst_decoder`.

---
 rtl/inst_fetch_aligner.sv | 149 ++++++++++++++
 tb/tb_inst_fetch_aligner.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_aligner.sv
// Instruction fetch aligner: turns aligned 32-bit memory words into a stream of
// 16/32-bit instructions via a halfword queue, with redirect and stale-response handling.
module inst_fetch_aligner #(
  parameter logic [63:0] INIT_ADDR = 64'h8000_0000,
  parameter int          QDEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [63:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  input  logic        flush,
  input  logic [63:0] flush_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_bits,
  output logic        if_is_rvc
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] CNT_HI = CW'(QDEPTH - 2);

  typedef enum logic [1:0] {IDLE, WAIT, WAIT_DISCARD} state_e;

  state_e          state_q, state_d;
  logic [63:0]     fetch_addr_q, fetch_addr_d;
  logic [63:0]     head_pc_q, head_pc_d;
  logic            drop_first_q, drop_first_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     mem_q [QDEPTH];

  logic [15:0]     h0, h1;
  logic            rvc, inst_ok;
  logic [1:0]      push_n, pop_n;
  logic            wr0_en, wr1_en;
  logic [15:0]     wr0_data;
  logic            unused_pc0;

  assign unused_pc0 = flush_pc[0];

  // Circular pointer advance by 0..2 entries; QDEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + {{(PW-1){1'b0}}, n};
    if (s >= (PW+1)'(QDEPTH)) s = s - (PW+1)'(QDEPTH);
    return s[PW-1:0];
  endfunction

  always_comb begin
    h0      = mem_q[rd_ptr_q];
    h1      = mem_q[ptr_add(rd_ptr_q, 2'd1)];
    rvc     = (h0[1:0] != 2'b11);
    inst_ok = ((count_q != '0) && rvc) || (count_q >= CW'(2));
  end

  // Outputs are zero whenever no instruction is presented, so stale queue data never leaks.
  assign if_valid  = inst_ok;
  assign if_is_rvc = inst_ok && rvc;
  assign if_bits   = !inst_ok ? 32'h0 : (rvc ? {16'h0, h0} : {h1, h0});
  assign if_pc     = inst_ok ? head_pc_q : 64'h0;
  assign req_valid = !rst && (state_q == IDLE) && !flush && (count_q <= CNT_HI);
  assign req_addr  = fetch_addr_q;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    head_pc_d    = head_pc_q;
    drop_first_d = drop_first_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    push_n       = 2'd0;
    pop_n        = 2'd0;
    wr0_en       = 1'b0;
    wr1_en       = 1'b0;
    wr0_data     = rsp_rdata[15:0];

    if (flush) begin
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      head_pc_d    = {flush_pc[63:1], 1'b0};
      fetch_addr_d = {flush_pc[63:2], 2'b00};
      drop_first_d = flush_pc[1];
      // A response landing with the flush is already consumed; otherwise an
      // outstanding request must still be drained.
      if (rsp_valid)             state_d = IDLE;
      else if (state_q == WAIT)  state_d = WAIT_DISCARD;
    end else begin
      if (req_valid && req_ready) begin
        state_d      = WAIT;
        fetch_addr_d = fetch_addr_q + 64'd4;
      end
      if (rsp_valid && (state_q == WAIT)) begin
        state_d = IDLE;
        wr0_en  = 1'b1;
        if (drop_first_q) begin
          wr0_data     = rsp_rdata[31:16];
          push_n       = 2'd1;
          drop_first_d = 1'b0;
        end else begin
          wr1_en = 1'b1;
          push_n = 2'd2;
        end
      end
      if (rsp_valid && (state_q == WAIT_DISCARD)) state_d = IDLE;
      if (inst_ok && if_ready) begin
        pop_n     = rvc ? 2'd1 : 2'd2;
        head_pc_d = head_pc_q + (rvc ? 64'd2 : 64'd4);
      end
      rd_ptr_d = ptr_add(rd_ptr_q, pop_n);
      wr_ptr_d = ptr_add(wr_ptr_q, push_n);
      count_d  = count_q + CW'(push_n) - CW'(pop_n);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_addr_q <= {INIT_ADDR[63:2], 2'b00};
      head_pc_q    <= INIT_ADDR;
      drop_first_q <= INIT_ADDR[1];
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      head_pc_q    <= head_pc_d;
      drop_first_q <= drop_first_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // Queue storage holds data only; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (wr0_en) mem_q[wr_ptr_q] <= wr0_data;
    if (wr1_en) mem_q[ptr_add(wr_ptr_q, 2'd1)] <= rsp_rdata[31:16];
  end

endmodule

// File: tb/tb_inst_fetch_aligner.sv
// Directed bench for inst_fetch_aligner: the bench plays instruction memory and
// decoder, driving on the falling edge and checking hand-computed expectations.
module tb_inst_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [63:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_rdata = 32'h0;
  logic        flush = 1'b0;
  logic [63:0] flush_pc = 64'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [63:0] if_pc;
  logic [31:0] if_bits;
  logic        if_is_rvc;

  int n_vec = 0;
  int n_err = 0;

  inst_fetch_aligner #(.INIT_ADDR(64'h8000_0000), .QDEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .flush(flush), .flush_pc(flush_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_bits(if_bits), .if_is_rvc(if_is_rvc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a request, check its address, and accept it.
  task automatic issue_req(input logic [63:0] addr);
    for (int i = 0; i < 20 && !req_valid; i++) @(negedge clk);
    check("req_valid", {63'h0, req_valid}, 64'h1);
    check("req_addr", req_addr, addr);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    rsp_valid = 1'b1;
    rsp_rdata = data;
    @(negedge clk);
    rsp_valid = 1'b0;
  endtask

  task automatic mem_word(input logic [63:0] addr, input logic [31:0] data);
    issue_req(addr);
    respond(data);
  endtask

  task automatic take(input logic [63:0] pc, input logic [31:0] bits, input logic rvc);
    check("if_valid", {63'h0, if_valid}, 64'h1);
    check("if_pc", if_pc, pc);
    check("if_bits", {32'h0, if_bits}, {32'h0, bits});
    check("if_is_rvc", {63'h0, if_is_rvc}, {63'h0, rvc});
    if_ready = 1'b1;
    @(negedge clk);
    if_ready = 1'b0;
  endtask

  task automatic do_flush(input logic [63:0] pc, input logic with_rsp);
    flush     = 1'b1;
    flush_pc  = pc;
    rsp_valid = with_rsp;
    rsp_rdata = 32'h0013_0013;
    #1;
    check("req_valid_in_flush", {63'h0, req_valid}, 64'h0);
    @(negedge clk);
    flush     = 1'b0;
    rsp_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_valid", {63'h0, req_valid}, 64'h0);
    check("rst_if_valid", {63'h0, if_valid}, 64'h0);
    check("rst_if_bits", {32'h0, if_bits}, 64'h0);
    check("rst_if_is_rvc", {63'h0, if_is_rvc}, 64'h0);
    check("rst_if_pc", if_pc, 64'h0);
    check("rst_req_addr", req_addr, 64'h8000_0000);
    rst = 1'b0;
    #1;

    // Reset fetch
    mem_word(64'h8000_0000, 32'h0000_0013);
    take(64'h8000_0000, 32'h0000_0013, 1'b0);

    // Two RVC in one word
    mem_word(64'h8000_0004, 32'h4501_4081);
    take(64'h8000_0004, 32'h0000_4081, 1'b1);
    take(64'h8000_0006, 32'h0000_4501, 1'b1);

    // Straddling 32-bit instruction
    mem_word(64'h8000_0008, 32'h0093_4501);
    take(64'h8000_0008, 32'h0000_4501, 1'b1);
    check("straddle_hold0", {63'h0, if_valid}, 64'h0);
    @(negedge clk);
    check("straddle_hold1", {63'h0, if_valid}, 64'h0);
    mem_word(64'h8000_000C, 32'h0001_0050);
    take(64'h8000_000A, 32'h0050_0093, 1'b0);
    take(64'h8000_000E, 32'h0000_0001, 1'b1);

    // Flush to odd halfword
    do_flush(64'h8000_0102, 1'b0);
    mem_word(64'h8000_0100, 32'h0001_0001);
    take(64'h8000_0102, 32'h0000_0001, 1'b1);
    check("odd_flush_empty", {63'h0, if_valid}, 64'h0);

    // Stale response while WAIT
    issue_req(64'h8000_0104);
    do_flush(64'h8000_0200, 1'b0);
    check("discard_no_req", {63'h0, req_valid}, 64'h0);
    respond(32'h1111_1111);
    check("stale_no_output", {63'h0, if_valid}, 64'h0);
    mem_word(64'h8000_0200, 32'h0002_0002);
    take(64'h8000_0200, 32'h0000_0002, 1'b1);
    take(64'h8000_0202, 32'h0000_0002, 1'b1);

    // Flush coinciding with the response
    issue_req(64'h8000_0204);
    do_flush(64'h8000_0300, 1'b1);
    check("coincide_no_output", {63'h0, if_valid}, 64'h0);
    mem_word(64'h8000_0300, 32'h0004_0004);
    take(64'h8000_0300, 32'h0000_0004, 1'b1);
    take(64'h8000_0302, 32'h0000_0004, 1'b1);

    // Backpressure: fill queue with four RVC halfwords
    mem_word(64'h8000_0304, 32'h000A_0008);
    mem_word(64'h8000_0308, 32'h000E_000C);
    for (int i = 0; i < 10; i++) begin
      check("bp_req_valid", {63'h0, req_valid}, 64'h0);
      @(negedge clk);
    end
    take(64'h8000_0304, 32'h0000_0008, 1'b1);
    take(64'h8000_0306, 32'h0000_000A, 1'b1);
    take(64'h8000_0308, 32'h0000_000C, 1'b1);
    take(64'h8000_030A, 32'h0000_000E, 1'b1);
    check("bp_drained", {63'h0, if_valid}, 64'h0);

    // Reset mid-transfer; the late response arrives in IDLE and is ignored
    issue_req(64'h8000_030C);
    rst = 1'b1;
    #1;
    check("midrst_req_valid", {63'h0, req_valid}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    respond(32'h0000_0013);
    check("midrst_no_output", {63'h0, if_valid}, 64'h0);
    mem_word(64'h8000_0000, 32'h0000_0013);
    take(64'h8000_0000, 32'h0000_0013, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
